thresholding_cfg_loader: RTL and testbench

//  Sequencer that streams threshold words from an AXI-Stream source into the AXI-Lite write port of the thresholding_axi core.
//  - Generates per-word byte addresses in the core's layout and runs one AW/W/B transaction at a time.
//  - Signals busy/done around a full load.
//  - Sits between a DMA/ROM stream and the core's s_axilite write channels; its AR/R channels are left to the host.

---
 rtl/thresholding_cfg_loader.sv | 201 ++++++++++++++++++++
 tb/tb_thresholding_cfg_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/thresholding_cfg_loader.sv
// Streams threshold words into the thresholding_axi AXI-Lite write port, one AW/W/B transaction at a time.
// Optional feature macro: THRESH_CFG_LOADER_ERRCNT_EN (counts non-OKAY write responses on err_cnt).
module thresholding_cfg_loader #(
  parameter int N  = 2,
  parameter int K  = 8,
  parameter int C  = 4,
  parameter int PE = 2
) (
  input  logic                                    ap_clk,
  input  logic                                    ap_rst_n,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    done,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  input  logic [31:0]                             s_axis_tdata,
  output logic                                    m_axilite_AWVALID,
  input  logic                                    m_axilite_AWREADY,
  output logic [$clog2(C/PE)+$clog2(PE)+N+1:0]    m_axilite_AWADDR,
  output logic                                    m_axilite_WVALID,
  input  logic                                    m_axilite_WREADY,
  output logic [31:0]                             m_axilite_WDATA,
  output logic [3:0]                              m_axilite_WSTRB,
  input  logic                                    m_axilite_BVALID,
  output logic                                    m_axilite_BREADY,
  input  logic [1:0]                              m_axilite_BRESP,
  output logic [15:0]                             err_cnt,
  output logic [2:0]                              dbg_state_o
);
  // Handshakes: a transfer happens on a rising ap_clk edge where VALID and READY are both high;
  // VALID and its payload never change while waiting for READY.
  localparam int T         = 2**N - 1;
  localparam int CF        = C / PE;
  localparam int CFB       = $clog2(CF);
  localparam int PEB       = $clog2(PE);
  localparam int ADDR_BITS = CFB + PEB + N + 2;
  localparam int CFW       = (CFB > 0) ? CFB : 1;
  localparam int PEW       = (PEB > 0) ? PEB : 1;

  localparam logic [N-1:0]   T_LAST  = N'(T - 1);
  localparam logic [PEW-1:0] PE_LAST = PEW'(PE - 1);
  localparam logic [CFW-1:0] CF_LAST = CFW'(CF - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  if (C % PE != 0) begin : g_cfg_check
    $error("thresholding_cfg_loader: C must be a multiple of PE");
  end

  logic [2:0]           state_q, state_d;
  logic [N-1:0]         t_q, t_d;
  logic [PEW-1:0]       pe_q, pe_d;
  logic [CFW-1:0]       cf_q, cf_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 aw_ok_q, aw_ok_d;
  logic                 w_ok_q, w_ok_d;
  logic [ADDR_BITS-1:0] awaddr_q, awaddr_d;
  logic [31:0]          wdata_q, wdata_d;

  logic [ADDR_BITS-1:0] word_addr;
  logic                 last_word;
  logic                 aw_acc, w_acc;

  // Unused counter fields (PE==1 or CF==1) stay at zero, so they contribute nothing to the address.
  assign word_addr = (ADDR_BITS'(cf_q) << (PEB + N + 2))
                   | (ADDR_BITS'(pe_q) << (N + 2))
                   | (ADDR_BITS'(t_q) << 2);
  assign last_word = (cf_q == CF_LAST) && (pe_q == PE_LAST) && (t_q == T_LAST);
  assign aw_acc    = aw_ok_q | (awvalid_q & m_axilite_AWREADY);
  assign w_acc     = w_ok_q | (wvalid_q & m_axilite_WREADY);

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    pe_d      = pe_q;
    cf_d      = cf_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_ok_d   = aw_ok_q;
    w_ok_d    = w_ok_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          t_d     = '0;
          pe_d    = '0;
          cf_d    = '0;
        end
      end
      S_FETCH: begin
        if (s_axis_tvalid) begin
          wdata_d   = 32'(s_axis_tdata[K-1:0]);
          awaddr_d  = word_addr;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_ok_d   = 1'b0;
          w_ok_d    = 1'b0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (awvalid_q && m_axilite_AWREADY) begin
          awvalid_d = 1'b0;
          aw_ok_d   = 1'b1;
        end
        if (wvalid_q && m_axilite_WREADY) begin
          wvalid_d = 1'b0;
          w_ok_d   = 1'b1;
        end
        if (aw_acc && w_acc) state_d = S_RESP;
      end
      S_RESP: begin
        if (m_axilite_BVALID) begin
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            if (t_q == T_LAST) begin
              t_d = '0;
              if (pe_q == PE_LAST) begin
                pe_d = '0;
                cf_d = cf_q + CFW'(1);
              end else begin
                pe_d = pe_q + PEW'(1);
              end
            end else begin
              t_d = t_q + N'(1);
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      pe_q      <= '0;
      cf_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_ok_q   <= 1'b0;
      w_ok_q    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      pe_q      <= pe_d;
      cf_q      <= cf_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_ok_q   <= aw_ok_d;
      w_ok_q    <= w_ok_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy              = (state_q == S_FETCH) || (state_q == S_ADDR) || (state_q == S_RESP);
  assign done              = (state_q == S_DONE);
  assign s_axis_tready     = (state_q == S_FETCH);
  assign m_axilite_BREADY  = (state_q == S_RESP);
  assign m_axilite_AWVALID = awvalid_q;
  assign m_axilite_WVALID  = wvalid_q;
  assign m_axilite_AWADDR  = awaddr_q;
  assign m_axilite_WDATA   = wdata_q;
  assign m_axilite_WSTRB   = 4'hF;
  assign dbg_state_o       = state_q;

`ifdef THRESH_CFG_LOADER_ERRCNT_EN
  logic [15:0] err_cnt_q;
  // Sticky across loads; only reset clears it.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_cnt_q <= 16'h0;
    end else if ((state_q == S_RESP) && m_axilite_BVALID && (m_axilite_BRESP != 2'b00)
                 && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'h1;
    end
  end
  assign err_cnt = err_cnt_q;
  logic unused_in;
  assign unused_in = ^s_axis_tdata;
`else
  assign err_cnt = 16'h0;
  logic unused_in;
  assign unused_in = ^{s_axis_tdata, m_axilite_BRESP};
`endif

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// Randomized bench for thresholding_cfg_loader: AXIS source, AXI-Lite write slave and a scoreboard of expected writes.
module tb_thresholding_cfg_loader;
  localparam int N     = 2;
  localparam int K     = 8;
  localparam int C     = 4;
  localparam int PE    = 2;
  localparam int T     = (1 << N) - 1;
  localparam int CF    = C / PE;
  localparam int PB    = $clog2(PE);
  localparam int AB    = $clog2(CF) + PB + N + 2;
  localparam int WORDS = CF * PE * T;
  localparam int W     = AB + 32;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          start;
  logic          busy, done;
  logic          s_axis_tvalid, s_axis_tready;
  logic [31:0]   s_axis_tdata;
  logic          m_axilite_AWVALID, m_axilite_AWREADY;
  logic [AB-1:0] m_axilite_AWADDR;
  logic          m_axilite_WVALID, m_axilite_WREADY;
  logic [31:0]   m_axilite_WDATA;
  logic [3:0]    m_axilite_WSTRB;
  logic          m_axilite_BVALID, m_axilite_BREADY;
  logic [1:0]    m_axilite_BRESP;
  logic [15:0]   err_cnt;
  logic [2:0]    dbg_state;

  thresholding_cfg_loader #(.N(N), .K(K), .C(C), .PE(PE)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .busy(busy), .done(done),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axilite_AWVALID(m_axilite_AWVALID), .m_axilite_AWREADY(m_axilite_AWREADY),
    .m_axilite_AWADDR(m_axilite_AWADDR), .m_axilite_WVALID(m_axilite_WVALID),
    .m_axilite_WREADY(m_axilite_WREADY), .m_axilite_WDATA(m_axilite_WDATA),
    .m_axilite_WSTRB(m_axilite_WSTRB), .m_axilite_BVALID(m_axilite_BVALID),
    .m_axilite_BREADY(m_axilite_BREADY), .m_axilite_BRESP(m_axilite_BRESP),
    .err_cnt(err_cnt), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  initial forever #5 ap_clk = ~ap_clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [31:0]   src_q[$];
  int            ld_idx, n_b, b_idx, done_cnt, busy_gap, exp_err;
  bit            in_load;
  logic [15:0]   err_mask;
  int            aw_fix, w_fix, b_fix, tv_pct;
  int            aw_dly, w_dly, b_dly, aw_wait, w_wait, b_wait;
  bit            aw_got, w_got, bvalid_r, tv_hold;
  bit            aw_stall, w_stall, aw_hs_prev, w_hs_prev;
  logic [AB-1:0] aw_seen, aw_prev;
  logic [31:0]   w_seen, w_prev;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Byte address of word i in cf-outer, pe, t-inner order.
  function automatic logic [AB-1:0] exp_addr(input int i);
    int t, pe, cf;
    t  = i % T;
    pe = (i / T) % PE;
    cf = i / (T * PE);
    return AB'(cf * (1 << (PB + N + 2)) + pe * (1 << (N + 2)) + t * 4);
  endfunction

  function automatic int pick(input int fix);
    return (fix >= 0) ? fix : int'($urandom_range(0, 3));
  endfunction

  task automatic pick_delays();
    aw_dly = pick(aw_fix);
    w_dly  = pick(w_fix);
    b_dly  = pick(b_fix);
  endtask

  // ---------------- AXIS source, AXI-Lite slave and monitor (driven at negedge) ----------------
  initial begin
    s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    m_axilite_AWREADY = 1'b0; m_axilite_WREADY = 1'b0;
    m_axilite_BVALID = 1'b0; m_axilite_BRESP = 2'b00;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        s_axis_tvalid = 1'b0; m_axilite_AWREADY = 1'b0; m_axilite_WREADY = 1'b0;
        m_axilite_BVALID = 1'b0; m_axilite_BRESP = 2'b00;
        aw_got = 0; w_got = 0; bvalid_r = 0; tv_hold = 0;
        aw_stall = 0; w_stall = 0; aw_hs_prev = 0; w_hs_prev = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0;
        continue;
      end
      if (done) begin
        done_cnt++;
        check_eq("done_busy_low", busy, 1'b0);
      end
      if (in_load && !busy && !done) busy_gap++;
      if (aw_stall)   check_eq("aw_hold", {m_axilite_AWVALID, m_axilite_AWADDR}, {1'b1, aw_prev});
      if (w_stall)    check_eq("w_hold", {m_axilite_WVALID, m_axilite_WDATA}, {1'b1, w_prev});
      if (aw_hs_prev) check_eq("aw_drop", m_axilite_AWVALID, 1'b0);
      if (w_hs_prev)  check_eq("w_drop", m_axilite_WVALID, 1'b0);
      if (m_axilite_BREADY) check_eq("bready_after_aw_w", {aw_got, w_got}, 2'b11);

      // B channel, driven only once both request handshakes have happened
      if (aw_got && w_got && !bvalid_r) begin
        if (b_wait >= b_dly) bvalid_r = 1;
        else b_wait++;
      end
      m_axilite_BVALID = bvalid_r;
      m_axilite_BRESP  = (bvalid_r && err_mask[b_idx]) ? 2'b10 : 2'b00;
      if (bvalid_r && m_axilite_BREADY) begin
        check_eq("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check_eq("write_addr_data", {aw_seen, w_seen}, exp_q.pop_front());
        n_b++; b_idx++;
        aw_got = 0; w_got = 0; bvalid_r = 0; b_wait = 0;
        pick_delays();
      end

      aw_hs_prev = 0;
      m_axilite_AWREADY = 1'b0;
      if (m_axilite_AWVALID && !aw_got) begin
        if (aw_wait >= aw_dly) begin
          m_axilite_AWREADY = 1'b1;
          aw_got = 1; aw_seen = m_axilite_AWADDR; aw_hs_prev = 1; aw_wait = 0;
        end else aw_wait++;
      end
      aw_stall = m_axilite_AWVALID && !m_axilite_AWREADY;
      aw_prev  = m_axilite_AWADDR;

      w_hs_prev = 0;
      m_axilite_WREADY = 1'b0;
      if (m_axilite_WVALID && !w_got) begin
        if (w_wait >= w_dly) begin
          m_axilite_WREADY = 1'b1;
          w_got = 1; w_seen = m_axilite_WDATA; w_hs_prev = 1; w_wait = 0;
          check_eq("wstrb", m_axilite_WSTRB, 4'hF);
        end else w_wait++;
      end
      w_stall = m_axilite_WVALID && !m_axilite_WREADY;
      w_prev  = m_axilite_WDATA;

      if (!tv_hold) begin
        if (src_q.size() > 0 && int'($urandom_range(0, 99)) < tv_pct) begin
          s_axis_tvalid = 1'b1; s_axis_tdata = src_q[0];
        end else s_axis_tvalid = 1'b0;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back({exp_addr(ld_idx), s_axis_tdata % (32'd1 << K)});
        void'(src_q.pop_front());
        ld_idx++;
        tv_hold = 0;
      end else tv_hold = s_axis_tvalid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_source(input int count, input int mode);
    src_q.delete(); exp_q.delete();
    for (int i = 0; i < count; i++) begin
      if (mode == 1) src_q.push_back(32'h10 + 32'(i));
      else src_q.push_back($urandom());
    end
    if (mode == 2) src_q[0] = 32'h1A5;
  endtask

  task automatic pulse_start();
    ld_idx = 0; n_b = 0; b_idx = 0; done_cnt = 0; busy_gap = 0;
    pick_delays();
    start = 1'b1;
    @(negedge ap_clk); #2;
    start = 1'b0;
    in_load = 1;
    check_eq("busy_after_start", busy, 1'b1);
  endtask

  task automatic run_load(input int extras, input int mode, input int restart_at, input logic [15:0] emask);
    int cyc;
    bit restarted;
    restarted = 0;
    err_mask = emask;
    fill_source(WORDS + extras, mode);
    pulse_start();
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      if (restart_at >= 0 && !restarted && ld_idx == restart_at) begin
        start = 1'b1; restarted = 1;
      end else start = 1'b0;
      @(negedge ap_clk); #2;
      cyc++;
    end
    start = 1'b0;
    check_eq("done_within_budget", done_cnt > 0, 1'b1);
    in_load = 0;
    repeat (4) @(negedge ap_clk);
    #2;
`ifdef THRESH_CFG_LOADER_ERRCNT_EN
    for (int i = 0; i < WORDS; i++) if (emask[i] && exp_err < 65535) exp_err++;
`endif
    check_eq("writes_per_load", n_b, WORDS);
    check_eq("single_done", done_cnt, 1);
    check_eq("sb_drained", exp_q.size(), 0);
    check_eq("extras_unconsumed", src_q.size(), extras);
    check_eq("busy_continuous", busy_gap, 0);
    check_eq("idle_after_load", {busy, s_axis_tready}, 2'b00);
    check_eq("err_cnt", err_cnt, exp_err);
  endtask

  task automatic reset_mid_load();
    int cyc;
    err_mask = '0;
    aw_fix = 2; w_fix = 0; b_fix = 0;
    fill_source(WORDS, 0);
    pulse_start();
    cyc = 0;
    while (!(ld_idx == 8 && m_axilite_AWVALID) && cyc < 3000) begin
      @(negedge ap_clk); #2;
      cyc++;
    end
    check_eq("reach_word7_addr", {ld_idx == 8, m_axilite_AWVALID}, 2'b11);
    ap_rst_n = 1'b0;
    #1;
    check_eq("reset_mid_outputs",
             {m_axilite_AWVALID, m_axilite_WVALID, m_axilite_BREADY, busy, done, s_axis_tready}, 6'b0);
    in_load = 0;
    repeat (2) @(negedge ap_clk);
    #2;
    exp_q.delete(); src_q.delete();
    exp_err = 0;
    ap_rst_n = 1'b1;
    @(negedge ap_clk); #2;
    check_eq("reset_err_cnt", err_cnt, 16'h0);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    ap_rst_n = 1'b0; start = 1'b0; in_load = 0; err_mask = '0; exp_err = 0;
    aw_fix = 0; w_fix = 0; b_fix = 0; tv_pct = 100;
    ld_idx = 0; n_b = 0; b_idx = 0; done_cnt = 0; busy_gap = 0;
    pick_delays();
    repeat (3) @(negedge ap_clk);
    #2;
    check_eq("reset_ctrl", {busy, done, s_axis_tready, m_axilite_AWVALID, m_axilite_WVALID, m_axilite_BREADY}, 6'b0);
    check_eq("reset_addr_data", {m_axilite_AWADDR, m_axilite_WDATA}, {W{1'b0}});
    check_eq("reset_wstrb", m_axilite_WSTRB, 4'hF);
    check_eq("reset_err_cnt0", err_cnt, 16'h0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk); #2;

    run_load(2, 1, -1, 16'h0);                         // sequential 0x10..0x1B, always-ready slave
    aw_fix = 3; w_fix = 0; b_fix = 1;
    run_load(1, 0, -1, 16'h0);                         // AWREADY held off 3 cycles
    aw_fix = 0; w_fix = 2; b_fix = 0;
    run_load(0, 2, -1, 16'h0);                         // first word 0x1A5 truncated to K bits
    aw_fix = -1; w_fix = -1; b_fix = -1; tv_pct = 70;
    run_load(1, 0, 5, 16'h0);                          // start pulsed while busy at word 5
    tv_pct = 100;
    reset_mid_load();
    aw_fix = 0; w_fix = 0; b_fix = 0;
    run_load(0, 1, -1, 16'h0);                         // reload after reset starts at address 0
    run_load(0, 0, -1, 16'h0204);                      // error responses on words 2 and 9
    aw_fix = -1; w_fix = -1; b_fix = -1; tv_pct = 60;
    for (int r = 0; r < 4; r++)
      run_load(int'($urandom_range(0, 3)), 0, -1, 16'($urandom()) & 16'h0FFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
